rijndael_round_ctrl: RTL

//  Round sequencer for one iterative Rijndael encryption core (any NB/NK in 4,6,8).

---
 rtl/rijndael_round_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/rijndael_round_ctrl.sv
// Round sequencer for an iterative Rijndael encryption core: seeds and steps the key schedule and strobes the datapath.
// Optional feature: define RIJNDAEL_CTRL_ABORT_EN to add abort_i, which cancels a running job.
module rijndael_round_ctrl #(
   parameter  int NB      = 4,
   parameter  int NK      = 4,
   localparam int KEYSIZE = 32 * NK,
   localparam int NR      = ((NB > NK) ? NB : NK) + 6,
   localparam int RW      = $clog2(NR + 1)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [KEYSIZE-1:0] key_i,
   output logic [KEYSIZE-1:0] ks_key_o,
   output logic               ks_rst_no,
   output logic               ks_enable_o,
   output logic               load_o,
   output logic               round_en_o,
   output logic [RW-1:0]      round_o,
   output logic               first_round_o,
   output logic               last_round_o,
   output logic               out_valid_o,
   input  logic               out_ready_i,
`ifdef RIJNDAEL_CTRL_ABORT_EN
   input  logic               abort_i,
`endif
   output logic               busy_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEED  = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [RW-1:0] NR_L = RW'(NR);

   state_t               r_state;
   logic   [RW-1:0]      r_round;
   logic                 r_ksRstN;
   logic   [KEYSIZE-1:0] r_ksKey;

   state_t               w_nextState;
   logic   [RW-1:0]      w_nextRound;
   logic                 w_nextKsRstN;
   logic                 w_accept;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= IDLE;
         r_round  <= '0;
         r_ksRstN <= 1'b0;
         r_ksKey  <= '0;
      end else begin
         r_state  <= w_nextState;
         r_round  <= w_nextRound;
         r_ksRstN <= w_nextKsRstN;
         if (w_accept) begin
            r_ksKey <= key_i;
         end
      end
   end

   // Accepting a job pulls the schedule reset low for exactly the SEED cycle so it reloads from the latched key.
   always_comb begin
      w_nextState  = r_state;
      w_nextRound  = r_round;
      w_nextKsRstN = 1'b1;
      w_accept     = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (in_valid_i) begin
               w_accept     = 1'b1;
               w_nextState  = SEED;
               w_nextRound  = '0;
               w_nextKsRstN = 1'b0;
            end
         end
         SEED: w_nextState = ROUND;
         ROUND: begin
            if (r_round == NR_L) begin
               w_nextState = DONE;
            end else begin
               w_nextRound = r_round + 1'b1;
            end
         end
         DONE: begin
            if (out_ready_i) begin
               w_nextState = IDLE;
               w_nextRound = '0;
            end
         end
         default: w_nextState = IDLE;
      endcase
`ifdef RIJNDAEL_CTRL_ABORT_EN
      if (abort_i && (r_state != IDLE)) begin
         w_nextState  = IDLE;
         w_nextRound  = '0;
         w_nextKsRstN = 1'b1;
         w_accept     = 1'b0;
      end
`endif
   end

   // Strobes depend only on registered state so no input reaches an output combinationally.
   always_comb begin
      in_ready_o    = (r_state == IDLE);
      load_o        = (r_state == SEED);
      round_en_o    = (r_state == ROUND);
      ks_enable_o   = (r_state == ROUND) && (r_round < NR_L);
      first_round_o = (r_state == ROUND) && (r_round == '0);
      last_round_o  = (r_state == ROUND) && (r_round == NR_L);
      out_valid_o   = (r_state == DONE);
      busy_o        = (r_state != IDLE);
   end

   assign round_o   = r_round;
   assign ks_rst_no = r_ksRstN;
   assign ks_key_o  = r_ksKey;

endmodule
